// File: rtl/wb_peripheral_bridge.sv
// Writeback-to-peripheral bridge: filters register writes by mask, queues them in a
// FIFO drained over valid/ready, and holds one inbound peripheral word in a mailbox.
module wb_peripheral_bridge #(
  parameter int          CORE         = 0,
  parameter int          DATA_WIDTH   = 32,
  parameter logic [31:0] REG_MASK     = 32'h03FC0200,
  parameter int          FIFO_DEPTH   = 4,
  parameter int          CHANNEL_BITS = 2,
  parameter int          OUT_CHANNEL  = 0,
  parameter int          CNT_WIDTH    = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    write,
  input  logic [4:0]              write_reg,
  input  logic [DATA_WIDTH-1:0]   write_data,
  output logic [CHANNEL_BITS-1:0] to_peripheral,
  output logic [4:0]              to_peripheral_reg,
  output logic [DATA_WIDTH-1:0]   to_peripheral_data,
  output logic                    to_peripheral_valid,
  input  logic                    to_peripheral_ready,
  input  logic [CHANNEL_BITS-1:0] from_peripheral,
  input  logic [DATA_WIDTH-1:0]   from_peripheral_data,
  input  logic                    from_peripheral_valid,
  output logic                    from_peripheral_ready,
  output logic [CHANNEL_BITS-1:0] mbox_channel,
  output logic [DATA_WIDTH-1:0]   mbox_data,
  output logic                    mbox_valid,
  input  logic                    mbox_read,
  output logic [CNT_WIDTH-1:0]    sent_count,
  output logic [CNT_WIDTH-1:0]    drop_count,
  output logic                    overflow,
  input  logic                    report
);

  localparam int                      PW         = $clog2(FIFO_DEPTH);
  localparam int                      OW         = PW + 1;
  localparam logic [OW-1:0]           FULL_LEVEL = OW'(FIFO_DEPTH);
  localparam logic [CHANNEL_BITS-1:0] OUT_TAG    = CHANNEL_BITS'(OUT_CHANNEL);
  localparam logic [CNT_WIDTH-1:0]    CNT_ONE    = CNT_WIDTH'(1);

  logic [4:0]              reg_mem_r  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   data_mem_r [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_r;
  logic [PW-1:0]           rd_ptr_r;
  logic [OW-1:0]           count_r;
  logic [CNT_WIDTH-1:0]    sent_count_r;
  logic [CNT_WIDTH-1:0]    drop_count_r;
  logic                    overflow_r;
  logic                    mbox_valid_r;
  logic [CHANNEL_BITS-1:0] mbox_channel_r;
  logic [DATA_WIDTH-1:0]   mbox_data_r;

  logic match_s;
  logic empty_s;
  logic full_s;
  logic pop_s;
  logic push_s;
  logic drop_s;
  logic mbox_load_s;
  logic mbox_clear_s;

  // Queue control: a full FIFO still accepts a push when the head leaves on the same edge.
  always_comb begin
    match_s      = 1'b0;
    empty_s      = 1'b0;
    full_s       = 1'b0;
    pop_s        = 1'b0;
    push_s       = 1'b0;
    drop_s       = 1'b0;
    mbox_load_s  = 1'b0;
    mbox_clear_s = 1'b0;
    match_s      = write && REG_MASK[write_reg] && (write_reg != 5'd0);
    empty_s      = (count_r == OW'(0));
    full_s       = (count_r == FULL_LEVEL);
    pop_s        = !empty_s && to_peripheral_ready;
    push_s       = match_s && (!full_s || pop_s);
    drop_s       = match_s && full_s && !pop_s;
    mbox_load_s  = from_peripheral_valid && !mbox_valid_r;
    mbox_clear_s = mbox_read && mbox_valid_r;
  end

  // Head-of-queue presentation; fields read as zero while nothing is queued.
  always_comb begin
    to_peripheral_valid = !empty_s;
    if (!empty_s) begin
      to_peripheral      = OUT_TAG;
      to_peripheral_reg  = reg_mem_r[rd_ptr_r];
      to_peripheral_data = data_mem_r[rd_ptr_r];
    end else begin
      to_peripheral      = {CHANNEL_BITS{1'b0}};
      to_peripheral_reg  = 5'd0;
      to_peripheral_data = {DATA_WIDTH{1'b0}};
    end
  end

  // Queue storage write port.
  always_ff @(posedge clock) begin
    if (push_s && !reset) begin
      reg_mem_r[wr_ptr_r]  <= write_reg;
      data_mem_r[wr_ptr_r] <= write_data;
    end
  end

  // Pointers, occupancy and statistics.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r     <= PW'(0);
      rd_ptr_r     <= PW'(0);
      count_r      <= OW'(0);
      sent_count_r <= {CNT_WIDTH{1'b0}};
      drop_count_r <= {CNT_WIDTH{1'b0}};
      overflow_r   <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + OW'(1);
        2'b01:   count_r <= count_r - OW'(1);
        default: count_r <= count_r;
      endcase
      if (pop_s && !(&sent_count_r)) sent_count_r <= sent_count_r + CNT_ONE;
      if (drop_s && !(&drop_count_r)) drop_count_r <= drop_count_r + CNT_ONE;
      if (drop_s) overflow_r <= 1'b1;
    end
  end

  // Inbound mailbox; ready depends only on registered state, so no same-edge refill.
  always_ff @(posedge clock) begin
    if (reset) begin
      mbox_valid_r   <= 1'b0;
      mbox_channel_r <= {CHANNEL_BITS{1'b0}};
      mbox_data_r    <= {DATA_WIDTH{1'b0}};
    end else if (mbox_load_s) begin
      mbox_valid_r   <= 1'b1;
      mbox_channel_r <= from_peripheral;
      mbox_data_r    <= from_peripheral_data;
    end else if (mbox_clear_s) begin
      mbox_valid_r   <= 1'b0;
    end
  end

  assign from_peripheral_ready = !mbox_valid_r;
  assign mbox_valid            = mbox_valid_r;
  assign mbox_channel          = mbox_channel_r;
  assign mbox_data             = mbox_data_r;
  assign sent_count            = sent_count_r;
  assign drop_count            = drop_count_r;
  assign overflow              = overflow_r;

`ifndef SYNTHESIS
  // Simulation trace of accepted reports and on-demand statistics.
  always @(posedge clock) begin
    if (!reset && push_s)
      $display(" Core %0d Register %0d Value = %0d", CORE, write_reg, write_data);
    if (report)
      $display(" Core %0d report: sent=%0d dropped=%0d occupancy=%0d",
               CORE, sent_count_r, drop_count_r, count_r);
  end
`endif

endmodule

// File: tb/tb_wb_peripheral_bridge.sv
// Directed self-checking bench for wb_peripheral_bridge with default parameters.
module tb_wb_peripheral_bridge;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        write = 1'b0;
  logic [4:0]  write_reg = 5'd0;
  logic [31:0] write_data = 32'd0;
  logic [1:0]  to_peripheral;
  logic [4:0]  to_peripheral_reg;
  logic [31:0] to_peripheral_data;
  logic        to_peripheral_valid;
  logic        to_peripheral_ready = 1'b0;
  logic [1:0]  from_peripheral = 2'd0;
  logic [31:0] from_peripheral_data = 32'd0;
  logic        from_peripheral_valid = 1'b0;
  logic        from_peripheral_ready;
  logic [1:0]  mbox_channel;
  logic [31:0] mbox_data;
  logic        mbox_valid;
  logic        mbox_read = 1'b0;
  logic [15:0] sent_count;
  logic [15:0] drop_count;
  logic        overflow;
  logic        report = 1'b0;

  int checks = 0;
  int failures = 0;

  wb_peripheral_bridge dut (
    .clock(clock), .reset(reset),
    .write(write), .write_reg(write_reg), .write_data(write_data),
    .to_peripheral(to_peripheral), .to_peripheral_reg(to_peripheral_reg),
    .to_peripheral_data(to_peripheral_data), .to_peripheral_valid(to_peripheral_valid),
    .to_peripheral_ready(to_peripheral_ready),
    .from_peripheral(from_peripheral), .from_peripheral_data(from_peripheral_data),
    .from_peripheral_valid(from_peripheral_valid), .from_peripheral_ready(from_peripheral_ready),
    .mbox_channel(mbox_channel), .mbox_data(mbox_data), .mbox_valid(mbox_valid),
    .mbox_read(mbox_read), .sent_count(sent_count), .drop_count(drop_count),
    .overflow(overflow), .report(report)
  );

  always #5 clock = ~clock;

  // Advance one edge; inputs are changed and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (to_peripheral_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0d exp=0", to_peripheral_valid); end
    checks++; if (to_peripheral_reg !== 5'd0 || to_peripheral_data !== 32'd0 || to_peripheral !== 2'd0) begin failures++; $display("FAIL reset_head got reg=%0d data=%0h tag=%0d exp all 0", to_peripheral_reg, to_peripheral_data, to_peripheral); end
    checks++; if (from_peripheral_ready !== 1'b1) begin failures++; $display("FAIL reset_fp_ready got=%0d exp=1", from_peripheral_ready); end
    checks++; if (mbox_valid !== 1'b0 || mbox_data !== 32'd0 || mbox_channel !== 2'd0) begin failures++; $display("FAIL reset_mbox got v=%0d d=%0h c=%0d exp 0", mbox_valid, mbox_data, mbox_channel); end
    checks++; if (sent_count !== 16'd0 || drop_count !== 16'd0 || overflow !== 1'b0) begin failures++; $display("FAIL reset_stats got s=%0d d=%0d o=%0d exp 0", sent_count, drop_count, overflow); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_push();
    to_peripheral_ready = 1'b1;
    write = 1'b1; write_reg = 5'd18; write_data = 32'd42;
    tick();
    write = 1'b0;
    checks++; if (to_peripheral_valid !== 1'b1) begin failures++; $display("FAIL push_valid got=%0d exp=1", to_peripheral_valid); end
    checks++; if (to_peripheral_reg !== 5'd18 || to_peripheral_data !== 32'd42) begin failures++; $display("FAIL push_head got reg=%0d data=%0d exp reg=18 data=42", to_peripheral_reg, to_peripheral_data); end
    checks++; if (to_peripheral !== 2'd0) begin failures++; $display("FAIL push_tag got=%0d exp=0", to_peripheral); end
    tick();
    checks++; if (to_peripheral_valid !== 1'b0) begin failures++; $display("FAIL push_drained got=%0d exp=0", to_peripheral_valid); end
    checks++; if (sent_count !== 16'd1) begin failures++; $display("FAIL push_sent got=%0d exp=1", sent_count); end
  endtask

  task automatic test_filter();
    logic [4:0] regs [3];
    regs[0] = 5'd5; regs[1] = 5'd0; regs[2] = 5'd26;
    to_peripheral_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      write = 1'b1; write_reg = regs[i]; write_data = 32'h55 + i;
      tick();
      write = 1'b0;
      checks++; if (to_peripheral_valid !== 1'b0) begin failures++; $display("FAIL filter_x%0d got valid=%0d exp=0", regs[i], to_peripheral_valid); end
    end
    tick();
    checks++; if (to_peripheral_valid !== 1'b0 || drop_count !== 16'd0) begin failures++; $display("FAIL filter_idle got v=%0d drop=%0d exp 0/0", to_peripheral_valid, drop_count); end
  endtask

  task automatic test_overflow();
    to_peripheral_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      write = 1'b1; write_reg = 5'(18 + i); write_data = 32'(i + 1);
      tick();
    end
    write = 1'b0;
    checks++; if (drop_count !== 16'd2) begin failures++; $display("FAIL ovf_drops got=%0d exp=2", drop_count); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0d exp=1", overflow); end
    tick();
    checks++; if (to_peripheral_valid !== 1'b1 || to_peripheral_reg !== 5'd18 || to_peripheral_data !== 32'd1) begin failures++; $display("FAIL ovf_hold got v=%0d reg=%0d data=%0d exp 1/18/1", to_peripheral_valid, to_peripheral_reg, to_peripheral_data); end
    to_peripheral_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (to_peripheral_valid !== 1'b1 || to_peripheral_reg !== 5'(18 + k) || to_peripheral_data !== 32'(k + 1)) begin failures++; $display("FAIL ovf_drain%0d got v=%0d reg=%0d data=%0d exp 1/%0d/%0d", k, to_peripheral_valid, to_peripheral_reg, to_peripheral_data, 18 + k, k + 1); end
      tick();
    end
    checks++; if (to_peripheral_valid !== 1'b0 || sent_count !== 16'd5) begin failures++; $display("FAIL ovf_empty got v=%0d sent=%0d exp 0/5", to_peripheral_valid, sent_count); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_data [4];
    exp_data[0] = 32'd12; exp_data[1] = 32'd13; exp_data[2] = 32'd14; exp_data[3] = 32'd99;
    to_peripheral_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      write = 1'b1; write_reg = 5'(19 + i); write_data = 32'(11 + i);
      tick();
    end
    to_peripheral_ready = 1'b1;
    write = 1'b1; write_reg = 5'd9; write_data = 32'd99;
    checks++; if (to_peripheral_data !== 32'd11) begin failures++; $display("FAIL full_head got=%0d exp=11", to_peripheral_data); end
    tick();
    write = 1'b0;
    checks++; if (drop_count !== 16'd2) begin failures++; $display("FAIL full_nodrop got=%0d exp=2", drop_count); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (to_peripheral_valid !== 1'b1 || to_peripheral_data !== exp_data[k]) begin failures++; $display("FAIL full_order%0d got v=%0d data=%0d exp 1/%0d", k, to_peripheral_valid, to_peripheral_data, exp_data[k]); end
      tick();
    end
    checks++; if (to_peripheral_valid !== 1'b0 || sent_count !== 16'd10) begin failures++; $display("FAIL full_done got v=%0d sent=%0d exp 0/10", to_peripheral_valid, sent_count); end
  endtask

  task automatic test_mailbox();
    from_peripheral_valid = 1'b1; from_peripheral = 2'd2; from_peripheral_data = 32'hABCD;
    checks++; if (from_peripheral_ready !== 1'b1) begin failures++; $display("FAIL mbox_ready_idle got=%0d exp=1", from_peripheral_ready); end
    tick();
    checks++; if (mbox_valid !== 1'b1 || mbox_data !== 32'hABCD || mbox_channel !== 2'd2) begin failures++; $display("FAIL mbox_load got v=%0d d=%0h c=%0d exp 1/abcd/2", mbox_valid, mbox_data, mbox_channel); end
    checks++; if (from_peripheral_ready !== 1'b0) begin failures++; $display("FAIL mbox_ready_full got=%0d exp=0", from_peripheral_ready); end
    from_peripheral = 2'd1; from_peripheral_data = 32'h1234;
    tick();
    checks++; if (mbox_data !== 32'hABCD || mbox_channel !== 2'd2) begin failures++; $display("FAIL mbox_block got d=%0h c=%0d exp abcd/2", mbox_data, mbox_channel); end
    mbox_read = 1'b1;
    tick();
    mbox_read = 1'b0;
    checks++; if (mbox_valid !== 1'b0 || from_peripheral_ready !== 1'b1 || mbox_data !== 32'hABCD) begin failures++; $display("FAIL mbox_read got v=%0d r=%0d d=%0h exp 0/1/abcd", mbox_valid, from_peripheral_ready, mbox_data); end
    tick();
    from_peripheral_valid = 1'b0;
    checks++; if (mbox_valid !== 1'b1 || mbox_data !== 32'h1234 || mbox_channel !== 2'd1) begin failures++; $display("FAIL mbox_refill got v=%0d d=%0h c=%0d exp 1/1234/1", mbox_valid, mbox_data, mbox_channel); end
    mbox_read = 1'b1;
    tick();
    tick();
    mbox_read = 1'b0;
    checks++; if (mbox_valid !== 1'b0 || mbox_data !== 32'h1234) begin failures++; $display("FAIL mbox_read_empty got v=%0d d=%0h exp 0/1234", mbox_valid, mbox_data); end
  endtask

  task automatic test_reset_mid();
    to_peripheral_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      write = 1'b1; write_reg = 5'(20 + i); write_data = 32'(7 + i);
      tick();
    end
    write = 1'b0;
    from_peripheral_valid = 1'b1; from_peripheral = 2'd3; from_peripheral_data = 32'hFEED;
    tick();
    from_peripheral_valid = 1'b0;
    checks++; if (to_peripheral_valid !== 1'b1 || mbox_valid !== 1'b1 || overflow !== 1'b1) begin failures++; $display("FAIL mid_pre got v=%0d mb=%0d o=%0d exp 1/1/1", to_peripheral_valid, mbox_valid, overflow); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (to_peripheral_valid !== 1'b0 || mbox_valid !== 1'b0 || from_peripheral_ready !== 1'b1) begin failures++; $display("FAIL mid_queue got v=%0d mb=%0d r=%0d exp 0/0/1", to_peripheral_valid, mbox_valid, from_peripheral_ready); end
    checks++; if (sent_count !== 16'd0 || drop_count !== 16'd0 || overflow !== 1'b0) begin failures++; $display("FAIL mid_stats got s=%0d d=%0d o=%0d exp 0", sent_count, drop_count, overflow); end
    tick();
    checks++; if (to_peripheral_valid !== 1'b0 || mbox_data !== 32'd0) begin failures++; $display("FAIL mid_after got v=%0d d=%0h exp 0/0", to_peripheral_valid, mbox_data); end
  endtask

  initial begin
    test_reset();
    test_basic_push();
    test_filter();
    test_overflow();
    test_full_push_pop();
    report = 1'b1;
    tick();
    report = 1'b0;
    test_mailbox();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_peripheral_bridge.md
Name: wb_peripheral_bridge

Overview:
Parametrised, buffered successor to the core's register-write-to-peripheral reporting path. It snoops the writeback bus, filters writes through a configurable register mask and queues matches in a FIFO. Entries drain to the peripheral over a valid/ready handshake, and a one-entry inbound mailbox carries data from the peripheral back to the core. It sits beside writeback_unit inside the core top, replacing the unbuffered always-block reporter.

Parameters:
CORE, 0, core id used in simulation display text
DATA_WIDTH, 32, writeback/peripheral data width
REG_MASK, 32'h03FC0200, bit i set = report writes to x[i] (default x9, x18-x25)
FIFO_DEPTH, 4, outbound queue entries; power of two, >=2
CHANNEL_BITS, 2, peripheral channel tag width
OUT_CHANNEL, 0, tag driven on to_peripheral for register reports
CNT_WIDTH, 16, width of statistics counters

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
write  input  1  writeback register-write strobe
write_reg  input  5  writeback destination register
write_data  input  DATA_WIDTH  writeback value
to_peripheral  output  CHANNEL_BITS  outbound channel tag
to_peripheral_reg  output  5  register index of the head entry
to_peripheral_data  output  DATA_WIDTH  value of the head entry
to_peripheral_valid  output  1  head entry valid
to_peripheral_ready  input  1  peripheral accepts head entry
from_peripheral  input  CHANNEL_BITS  inbound channel tag
from_peripheral_data  input  DATA_WIDTH  inbound data
from_peripheral_valid  input  1  inbound data valid
from_peripheral_ready  output  1  mailbox can accept
mbox_channel  output  CHANNEL_BITS  latched inbound tag
mbox_data  output  DATA_WIDTH  latched inbound data
mbox_valid  output  1  mailbox holds unread data
mbox_read  input  1  core consumes mailbox (1-cycle pulse)
sent_count  output  CNT_WIDTH  entries accepted by peripheral, saturating
drop_count  output  CNT_WIDTH  matches lost to full FIFO, saturating
overflow  output  1  sticky: at least one drop since reset
report  input  1  performance-report strobe

Behaviour:
- Reset (synchronous, active-high): FIFO empty, pointers zero, to_peripheral_valid=0, to_peripheral=0, to_peripheral_reg=0, to_peripheral_data=0, mbox_valid=0, mbox_channel=0, mbox_data=0, from_peripheral_ready=1 from the first cycle after reset, counters=0, overflow=0. Reset mid-operation discards all queued and mailbox contents.
- Match condition: write && REG_MASK[write_reg] && write_reg!=0. x0 is never reported, whatever the mask says.
- Push: a match at edge N enqueues {write_reg, write_data}. With the FIFO previously empty, to_peripheral_valid=1 after edge N (one-cycle latency, same as the legacy reporter). There is no combinational bypass.
- Outputs: to_peripheral_valid = !empty. Reg/data show the head entry and stay stable while valid && !ready. to_peripheral = OUT_CHANNEL while valid, 0 otherwise.
- Pop: valid && to_peripheral_ready at an edge removes the head and increments sent_count.
- Full FIFO:
  - Push with simultaneous pop is accepted, with no drop.
  - Push without pop is discarded; drop_count increments and overflow is set.
  - Counters saturate at all-ones.
- Occupancy counter spans 0..FIFO_DEPTH (log2(FIFO_DEPTH)+1 bits). Read and write pointers wrap modulo FIFO_DEPTH.
- Mailbox: from_peripheral_ready = !mbox_valid (registered state only). valid && ready at an edge latches channel and data and sets mbox_valid.
  - mbox_read while mbox_valid clears it at that edge. Ready rises next cycle; same-edge refill is not allowed.
  - mbox_read while empty is ignored.
  - mbox_data holds its last value after a read.
- Report (simulation only): on report=1, $display core id, sent_count, drop_count and occupancy. report has no effect on hardware state.
- Each accepted push also $displays " Core [CORE] Register [reg] Value = data" (simulation only).

Test Plan:
- Reset, then write=1, write_reg=18, write_data=42 with ready=1 -> valid=1 the next cycle with reg=18, data=42, tag=0; after the handshake valid=0 and sent_count=1.
- Writes to x5, x0 and x26 under the default mask -> valid stays 0 and no entry is queued.
- ready=0; six matching writes (x18..x23, data 1..6) with FIFO_DEPTH=4 -> queue holds 1..4, drop_count=2, overflow=1; raising ready drains exactly 1,2,3,4 in order.
- FIFO full while ready=1 and a new match (x9, data 99) arrives in the same cycle -> no drop; 99 is delivered after the existing three entries.
- Inbound: from_peripheral_valid=1, data=0xABCD, tag=2 -> mbox_valid=1 and ready=0; a second offer is not accepted; mbox_read -> mbox_valid=0, and the second offer is accepted one cycle later.
- Assert reset with 3 entries queued and the mailbox full -> the next cycle shows valid=0, mbox_valid=0, counters=0, overflow=0, from_peripheral_ready=1.
